// File: rtl/simple_tb_pkg.sv
// Shared types and helpers for the pattern generator and its LFSR.
// Functions work on 32-bit containers; callers truncate to their own width.
package simple_tb_pkg;

    localparam int unsigned LfsrMaxW = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } pg_state_e;

    // Galois step: shift right, fold the feedback mask in when bit 0 falls out.
    function automatic logic [LfsrMaxW-1:0] lfsr_next(input logic [LfsrMaxW-1:0] x,
                                                       input logic [LfsrMaxW-1:0] poly);
        logic [LfsrMaxW-1:0] shifted;
        shifted = x >> 1;
        return x[0] ? (shifted ^ poly) : shifted;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR register with synchronous load and advance; load wins over advance.
module lfsr_galois
    import simple_tb_pkg::*;
#(
    parameter int unsigned         WIDTH = 8,
    parameter logic [WIDTH-1:0]    POLY  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             adv,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [LfsrMaxW-1:0] step;

    always_comb begin
        step = lfsr_next(LfsrMaxW'(q_q), LfsrMaxW'(POLY));
        q_d  = q_q;
        if (load) begin
            q_d = seed;
        end else if (adv) begin
            q_d = step[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

    // The upper bits of the 32-bit step are always zero for a WIDTH-bit mask.
    logic unused_step;
    assign unused_step = ^step;

endmodule

// File: rtl/pattern_gen.sv
// LFSR-driven reference pattern source that checks a looped-back response,
// counting mismatches and recording the index of the first one.
module pattern_gen
    import simple_tb_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] POLY    = 8'hB8,
    parameter logic [WIDTH-1:0] SEED    = 8'h01,
    parameter int unsigned      NUM_VEC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] test,
    output logic [WIDTH-1:0] pat,
    output logic             pat_valid,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_idx,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_err
);

    localparam logic [WIDTH-1:0] SeedOne = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SeedEff = (SEED == '0) ? SeedOne : SEED;
    localparam logic [15:0]      LastIdx = 16'(NUM_VEC - 1);

    pg_state_e        state_q;
    logic [15:0]      vec_idx_q;
    logic [15:0]      err_cnt_q;
    logic [15:0]      first_err_q;
    logic [WIDTH-1:0] lfsr_q;

    logic check;
    logic last;
    logic mismatch;
    logic lfsr_load;
    logic lfsr_adv;

    always_comb begin
        check     = (state_q == StRun) && !hold;
        last      = check && (vec_idx_q == LastIdx);
`ifdef SYNTHESIS
        mismatch  = check && (test != lfsr_q);
`else
        mismatch  = check && (test !== lfsr_q);
`endif
        lfsr_load = start && (state_q != StRun);
        // Not advancing on the final check keeps the last vector on pat in DONE.
        lfsr_adv  = check && !last;
    end

    lfsr_galois #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SeedEff),
        .adv   (lfsr_adv),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_idx_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q     <= StRun;
                        vec_idx_q   <= '0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                    end
                end
                StRun: begin
                    if (check) begin
                        if (mismatch) begin
                            err_cnt_q <= sat_inc16(err_cnt_q);
                            if (err_cnt_q == '0) begin
                                first_err_q <= vec_idx_q;
                            end
                        end
                        if (last) begin
                            state_q <= StDone;
                        end else begin
                            vec_idx_q <= vec_idx_q + 16'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pat       = lfsr_q;
    assign pat_valid = check;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign vec_idx   = vec_idx_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

`ifndef SYNTHESIS
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRun) |-> (lfsr_q != '0));
    a_idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRun) |-> (vec_idx_q <= LastIdx));
`endif

endmodule
